// File: rtl/buffer_ring_manager_if.sv
// DataMover S2MM command channel between the ring manager (master) and the DataMover (slave).
interface buffer_ring_manager_if #(
    parameter int MM_ADDR_WIDTH = 32
) ();
    logic                       tvalid;
    logic                       tready;
    logic [MM_ADDR_WIDTH+39:0]  tdata;

    modport master (
        output tvalid,
        output tdata,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        output tready
    );
endinterface

// File: rtl/buffer_ring_manager.sv
// Ring of BUFFER_COUNT DataMover buffers: issues one S2MM command per buffer, counts samples
// into it, and hands the CPU a locked, fully written buffer that the writer then steps around.
module buffer_ring_manager #(
    parameter int MM_ADDR_WIDTH = 32,
    parameter int BUFFER_COUNT  = 4
) (
    input  logic                        SYS_aclk,
    input  logic                        SYS_aresetn,
    input  logic                        SM_enable,
    input  logic                        SM_sample_valid,
    input  logic [4:0]                  SM_log_length,
    input  logic [MM_ADDR_WIDTH-1:0]    SM_base_address,
    input  logic [MM_ADDR_WIDTH-1:0]    SM_stride,
    input  logic                        SM_request,
    output logic [MM_ADDR_WIDTH-1:0]    SM_read_buffer,
    output logic                        SM_read_valid,
    output logic [15:0]                 SM_drop_count,
    buffer_ring_manager_if.master       m_axis
);

    localparam int          IW = $clog2(BUFFER_COUNT);
    localparam logic [IW:0] NB = (IW+1)'(BUFFER_COUNT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        FILL = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;

    logic [IW-1:0]               r_write_idx;
    logic [IW-1:0]               r_full_idx;
    logic                        r_has_full;
    logic [IW-1:0]               r_lock_idx;
    logic                        r_locked;
    logic [22:0]                 r_count;
    logic [22:0]                 r_len_q;
    logic                        r_tvalid;
    logic [MM_ADDR_WIDTH+39:0]   r_tdata;
    logic [MM_ADDR_WIDTH-1:0]    r_read_buffer;
    logic                        r_read_valid;
    logic [15:0]                 r_drop_count;

    logic [22:0]                 w_len;
    logic                        w_sample_in_fill;
    logic                        w_complete;
    logic                        w_enter_cmd;
    logic                        w_handshake;
    logic                        w_drop;
    logic [IW-1:0]               w_next_free;
    logic [IW-1:0]               w_cmd_idx;
    logic [IW-1:0]               w_lock_src;
    logic [MM_ADDR_WIDTH+39:0]   w_cmd_word;
    logic [IW-1:0]               w_cand [BUFFER_COUNT-1];
    logic [BUFFER_COUNT-2:0]     w_free;

    function automatic logic [MM_ADDR_WIDTH-1:0] buf_addr(
        input logic [IW-1:0]              idx,
        input logic [MM_ADDR_WIDTH-1:0]   base,
        input logic [MM_ADDR_WIDTH-1:0]   stride
    );
        return base + MM_ADDR_WIDTH'(idx) * stride;
    endfunction

    // Lengths above 2^22 do not fit the 23-bit BTT field, so the exponent saturates at 22.
    assign w_len = (SM_log_length > 5'd22) ? (23'd1 << 22) : (23'd1 << SM_log_length);

    assign w_handshake      = (r_state == CMD) && m_axis.tready;
    assign w_sample_in_fill = (r_state == FILL) && SM_enable && SM_sample_valid;
    assign w_complete       = w_sample_in_fill && (r_count == r_len_q - 23'd1);
    assign w_drop           = (r_state != FILL) && SM_enable && SM_sample_valid;

    // Candidates write_idx+1 .. write_idx+N-1 (mod N); write_idx itself is never one of them.
    genvar gi;
    generate
        for (gi = 0; gi < BUFFER_COUNT-1; gi++) begin : g_cand
            logic [IW:0] w_sum;
            assign w_sum       = {1'b0, r_write_idx} + (IW+1)'(gi + 1);
            assign w_cand[gi]  = IW'((w_sum >= NB) ? (w_sum - NB) : w_sum);
            assign w_free[gi]  = !(r_locked && (w_cand[gi] == r_lock_idx));
        end
    endgenerate

    // Scan from the far end so the nearest free candidate is the one left standing.
    always_comb begin
        w_next_free = w_cand[0];
        for (int k = BUFFER_COUNT-2; k >= 0; k--) begin
            if (w_free[k]) begin
                w_next_free = w_cand[k];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (SM_enable) w_state_next = CMD;
            end
            CMD: begin
                if (m_axis.tready) w_state_next = SM_enable ? FILL : IDLE;
            end
            FILL: begin
                if (!SM_enable)      w_state_next = IDLE;
                else if (w_complete) w_state_next = CMD;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_enter_cmd = (w_state_next == CMD) && (r_state != CMD);
    assign w_cmd_idx   = w_complete ? w_next_free : r_write_idx;
    assign w_lock_src  = w_complete ? r_write_idx : r_full_idx;

    // RSVD, TAG, SADDR, DRR, EOF, DSA, Type=1 (incrementing), BTT
    assign w_cmd_word = {4'b0000, 4'b0000,
                         buf_addr(w_cmd_idx, SM_base_address, SM_stride),
                         1'b0, 1'b0, 6'b000000, 1'b1, w_len};

    always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
        if (!SYS_aresetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
        if (!SYS_aresetn) begin
            r_write_idx   <= '0;
            r_full_idx    <= '0;
            r_has_full    <= 1'b0;
            r_lock_idx    <= '0;
            r_locked      <= 1'b0;
            r_count       <= '0;
            r_len_q       <= '0;
            r_tvalid      <= 1'b0;
            r_tdata       <= '0;
            r_read_buffer <= '0;
            r_read_valid  <= 1'b0;
            r_drop_count  <= '0;
        end else begin
            r_tvalid <= (w_state_next == CMD);

            if (w_enter_cmd) begin
                r_tdata <= w_cmd_word;
                r_len_q <= w_len;
            end

            if (w_handshake && SM_enable) begin
                r_count <= '0;
            end else if (w_complete) begin
                r_count     <= '0;
                r_full_idx  <= r_write_idx;
                r_has_full  <= 1'b1;
                r_write_idx <= w_next_free;
            end else if (w_sample_in_fill) begin
                r_count <= r_count + 23'd1;
            end

            if (w_drop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end

            // A buffer finishing on the request cycle is the freshest, so it is the one locked.
            if (!SM_request) begin
                r_locked      <= 1'b0;
                r_read_buffer <= '0;
                r_read_valid  <= 1'b0;
            end else if (!r_locked) begin
                r_locked      <= 1'b1;
                r_lock_idx    <= w_lock_src;
                r_read_buffer <= buf_addr(w_lock_src, SM_base_address, SM_stride);
                r_read_valid  <= r_has_full || w_complete;
            end
        end
    end

    assign m_axis.tvalid  = r_tvalid;
    assign m_axis.tdata   = r_tdata;
    assign SM_read_buffer = r_read_buffer;
    assign SM_read_valid  = r_read_valid;
    assign SM_drop_count  = r_drop_count;

endmodule

// File: tb/tb_buffer_ring_manager.sv
// Scoreboard bench for buffer_ring_manager: expected DataMover commands are queued as each
// buffer is driven and compared on every handshake; reader and drop outputs checked inline.
module tb_buffer_ring_manager;

    localparam int AW = 32;
    localparam int N  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        sample = 1'b0;
    logic        request = 1'b0;
    logic [4:0]  log_len = 5'd4;
    logic [31:0] base = 32'h1000_0000;
    logic [31:0] stride = 32'h0000_1000;
    logic [31:0] read_buffer;
    logic        read_valid;
    logic [15:0] drop_count;

    int          total = 0;
    int          bad = 0;
    logic [71:0] exp_q [$];

    always #5 clk = ~clk;

    buffer_ring_manager_if #(.MM_ADDR_WIDTH(AW)) m_axis ();

    buffer_ring_manager #(
        .MM_ADDR_WIDTH (AW),
        .BUFFER_COUNT  (N)
    ) dut (
        .SYS_aclk        (clk),
        .SYS_aresetn     (rst_n),
        .SM_enable       (enable),
        .SM_sample_valid (sample),
        .SM_log_length   (log_len),
        .SM_base_address (base),
        .SM_stride       (stride),
        .SM_request      (request),
        .SM_read_buffer  (read_buffer),
        .SM_read_valid   (read_valid),
        .SM_drop_count   (drop_count),
        .m_axis          (m_axis)
    );

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    function automatic logic [71:0] cmd_word(input int idx, input logic [22:0] btt);
        logic [31:0] a;
        a = 32'h1000_0000 + 32'(idx) * 32'h0000_1000;
        return {8'h00, a, 2'b00, 6'b000000, 1'b1, btt};
    endfunction

    // Command monitor: every accepted command must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && m_axis.tvalid && m_axis.tready) begin
            if (exp_q.size() == 0) begin
                check("cmd_unexpected_qsize", 72'(exp_q.size()), 72'd1);
            end else begin
                check("cmd", m_axis.tdata, exp_q.pop_front());
            end
        end
    end

    task automatic wait_hs(input string tag);
        int  n;
        bit  seen;
        n = 0;
        seen = 0;
        while (!seen && n < 64) begin
            @(negedge clk);
            if (m_axis.tvalid && m_axis.tready) seen = 1;
            else n++;
        end
        if (!seen) check({tag, "_timeout"}, 72'(n), 72'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int n);
        sample = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        sample = 1'b0;
    endtask

    initial begin
        int seq3 [8] = '{3, 0, 2, 3, 0, 2, 3, 0};
        m_axis.tready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", 72'(m_axis.tvalid), 72'd0);
        check("rst_tdata", m_axis.tdata, 72'd0);
        check("rst_read_buffer", 72'(read_buffer), 72'd0);
        check("rst_read_valid", 72'(read_valid), 72'd0);
        check("rst_drop", 72'(drop_count), 72'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Ring walk with tready tied high
        enable = 1'b1;
        exp_q.push_back(cmd_word(0, 23'd16));
        exp_q.push_back(cmd_word(1, 23'd16));
        exp_q.push_back(cmd_word(2, 23'd16));
        exp_q.push_back(cmd_word(3, 23'd16));
        exp_q.push_back(cmd_word(0, 23'd16));
        wait_hs("t1_first");
        for (int i = 0; i < 4; i++) begin
            fill(16);
            wait_hs("t1_next");
        end
        check("t1_drop", 72'(drop_count), 72'd0);

        // Back-pressure: command must hold steady, samples meanwhile count as drops
        m_axis.tready = 1'b0;
        fill(16);
        for (int i = 0; i < 5; i++) begin
            sample = (i < 3);
            @(negedge clk);
            check("t2_tvalid_hold", 72'(m_axis.tvalid), 72'd1);
            check("t2_tdata_hold", m_axis.tdata, cmd_word(1, 23'd16));
            @(posedge clk);
            #1;
        end
        sample = 1'b0;
        exp_q.push_back(cmd_word(1, 23'd16));
        m_axis.tready = 1'b1;
        wait_hs("t2_release");
        check("t2_drop", 72'(drop_count), 72'd3);

        // Lock buffer 1 and keep it across eight fills
        exp_q.push_back(cmd_word(2, 23'd16));
        fill(16);
        request = 1'b1;
        wait_hs("t3_lock");
        check("t3_read_buffer", 72'(read_buffer), 72'h1000_1000);
        check("t3_read_valid", 72'(read_valid), 72'd1);
        for (int i = 0; i < 8; i++) exp_q.push_back(cmd_word(seq3[i], 23'd16));
        for (int i = 0; i < 8; i++) begin
            fill(16);
            wait_hs("t3_fill");
            check("t3_read_buffer_held", 72'(read_buffer), 72'h1000_1000);
        end
        request = 1'b0;
        @(posedge clk);
        #1;
        check("t3_unlock_buffer", 72'(read_buffer), 72'd0);
        check("t3_unlock_valid", 72'(read_valid), 72'd0);

        // Request rises on the very cycle buffer 0 completes
        exp_q.push_back(cmd_word(1, 23'd16));
        sample = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        request = 1'b1;
        @(posedge clk);
        #1;
        sample = 1'b0;
        check("t4_read_buffer", 72'(read_buffer), 72'h1000_0000);
        check("t4_read_valid", 72'(read_valid), 72'd1);
        wait_hs("t4_cmd");
        request = 1'b0;

        // Asynchronous reset while a command is pending
        m_axis.tready = 1'b0;
        fill(16);
        @(negedge clk);
        check("t6_tvalid_pre", 72'(m_axis.tvalid), 72'd1);
        check("t6_tdata_pre", m_axis.tdata, cmd_word(2, 23'd16));
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_tvalid_async", 72'(m_axis.tvalid), 72'd0);
        check("t6_tdata_async", m_axis.tdata, 72'd0);
        check("t6_drop_async", 72'(drop_count), 72'd0);
        enable = 1'b0;
        log_len = 5'd31;
        m_axis.tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Request before any completion; oversized log length clamps BTT
        exp_q.push_back(cmd_word(0, 23'h40_0000));
        enable = 1'b1;
        request = 1'b1;
        @(posedge clk);
        #1;
        check("t5_read_buffer", 72'(read_buffer), 72'h1000_0000);
        check("t5_read_valid", 72'(read_valid), 72'd0);
        wait_hs("t5_cmd");
        check("t5_drop", 72'(drop_count), 72'd0);
        request = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 72'(exp_q.size()), 72'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
